// File: rtl/exc_arbiter_if.sv
// exc_arbiter_if: exception record handshake between the arbiter and COP0.
interface exc_arbiter_if #(
    parameter int CODE_W = 5,
    parameter int CNT_W  = 16
);
    logic              exc_valid;
    logic              exc_ready;
    logic [CODE_W-1:0] exc_code;
    logic [31:0]       exc_epc;
    logic              exc_bd;
    logic [31:0]       exc_badva;
    logic              exc_wr_badva;
    logic [CNT_W-1:0]  exc_count;

    modport master (
        output exc_valid, exc_code, exc_epc, exc_bd, exc_badva, exc_wr_badva, exc_count,
        input  exc_ready
    );

    modport slave (
        input  exc_valid, exc_code, exc_epc, exc_bd, exc_badva, exc_wr_badva, exc_count,
        output exc_ready
    );
endinterface

// File: rtl/exc_arbiter.sv
// exc_arbiter: picks the highest-priority live exception, flushes the pipeline,
// computes the vector PC and hands the captured record to COP0.
module exc_arbiter #(
    parameter int NUM_SRC   = 17,
    parameter int NUM_STAGE = 3,
    parameter int STG_W     = 2,
    parameter int CODE_W    = 5,
    parameter int INT_SRC   = 16,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_req,
    input  logic [NUM_SRC*CODE_W-1:0]   src_code,
    input  logic [NUM_SRC*STG_W-1:0]    src_stage,
    input  logic [NUM_SRC-1:0]          src_badva,
    input  logic [NUM_SRC-1:0]          src_tlbref,
    input  logic [NUM_STAGE*32-1:0]     stage_pc,
    input  logic [NUM_STAGE-1:0]        stage_bd,
    input  logic [NUM_STAGE*32-1:0]     stage_vaddr,
    input  logic [NUM_STAGE-1:0]        stage_kill,
    input  logic                        eret,
    input  logic                        status_exl,
    input  logic                        status_erl,
    input  logic                        status_bev,
    input  logic                        cause_iv,
    input  logic [31:0]                 epc_in,
    input  logic [31:0]                 errorepc_in,
    output logic [NUM_STAGE-1:0]        flush,
    output logic [31:0]                 exc_pc,
    output logic                        use_exc_pc,
    output logic                        hold,
    exc_arbiter_if.master               cop
);
    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int NPAD  = 2**STG_W;

    typedef enum logic {IDLE, HOLD} arbState;
    arbState state, stateNext;

    logic [STG_W-1:0]  srcStage [NUM_SRC];
    logic [CODE_W-1:0] srcCode  [NUM_SRC];
    logic [31:0]       pcArr    [NPAD+1];
    logic [31:0]       vaArr    [NPAD];
    logic [NPAD-1:0]   bdArr;
    logic [NPAD-1:0]   killArr;
    logic [NUM_SRC-1:0] live;
    logic [SEL_W-1:0]  sel;
    logic              taken;
    logic              eretLive;
    logic [STG_W-1:0]  selStage;
    logic [STG_W:0]    selNext;
    logic [31:0]       vecBase;
    logic [31:0]       vecOff;
    logic [31:0]       epcSel;

    genvar g;
    // Stage tags may address unused encodings; those read as zero / not killed.
    for (g = 0; g <= NPAD; g++) begin : gPc
        if (g < NUM_STAGE) begin : gUsed
            assign pcArr[g] = stage_pc[g*32 +: 32];
        end else begin : gUnused
            assign pcArr[g] = '0;
        end
    end

    for (g = 0; g < NPAD; g++) begin : gStage
        if (g < NUM_STAGE) begin : gUsed
            assign vaArr[g]   = stage_vaddr[g*32 +: 32];
            assign bdArr[g]   = stage_bd[g];
            assign killArr[g] = stage_kill[g];
        end else begin : gUnused
            assign vaArr[g]   = '0;
            assign bdArr[g]   = 1'b0;
            assign killArr[g] = 1'b0;
        end
    end

    for (g = 0; g < NUM_SRC; g++) begin : gSrc
        assign srcStage[g] = src_stage[g*STG_W +: STG_W];
        assign srcCode[g]  = src_code[g*CODE_W +: CODE_W];
        assign live[g]     = src_req[g] & ~killArr[srcStage[g]] & ~hold &
                             ((g == INT_SRC) ? ~(status_exl | status_erl) : 1'b1);
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (live[i]) sel = SEL_W'(i);
    end

    assign taken    = |live;
    assign selStage = srcStage[sel];
    assign selNext  = {1'b0, selStage} + (STG_W+1)'(1);
    assign eretLive = eret & ~hold & ~taken;

    for (g = 0; g < NUM_STAGE; g++) begin : gFlush
        assign flush[g] = eretLive | (taken & (int'(selStage) >= g));
    end

    assign vecBase    = status_bev ? 32'hBFC0_0200 : 32'h8000_0000;
    assign vecOff     = (src_tlbref[sel] & ~status_exl) ? 32'h0 :
                        ((int'(sel) == INT_SRC) && cause_iv) ? 32'h200 : 32'h180;
    assign exc_pc     = eretLive ? (status_erl ? errorepc_in : epc_in) : vecBase + vecOff;
    assign use_exc_pc = taken | eretLive;

    // A delay-slot fault reports the branch; the oldest stage has no older neighbour.
    assign epcSel = ~bdArr[selStage] ? pcArr[selStage] :
                    (int'(selStage) == NUM_STAGE - 1) ? pcArr[selStage] - 32'd4 :
                    pcArr[selNext];

    always_comb begin
        stateNext = (state == IDLE) ? (taken ? HOLD : IDLE) : (cop.exc_ready ? IDLE : HOLD);
    end

    assign hold          = (state == HOLD);
    assign cop.exc_valid = hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            cop.exc_code     <= '0;
            cop.exc_epc      <= '0;
            cop.exc_bd       <= 1'b0;
            cop.exc_badva    <= '0;
            cop.exc_wr_badva <= 1'b0;
            cop.exc_count    <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && taken) begin
                cop.exc_code     <= srcCode[sel];
                cop.exc_epc      <= epcSel;
                cop.exc_bd       <= bdArr[selStage];
                cop.exc_badva    <= vaArr[selStage];
                cop.exc_wr_badva <= src_badva[sel];
                cop.exc_count    <= (&cop.exc_count) ? cop.exc_count : cop.exc_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter: directed scenario tests for exc_arbiter with hand-computed expectations.
module tb_exc_arbiter;
    localparam int NUM_SRC = 17, NUM_STAGE = 3, STG_W = 2, CODE_W = 5, CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NUM_SRC-1:0]        src_req;
    logic [NUM_SRC*CODE_W-1:0] src_code;
    logic [NUM_SRC*STG_W-1:0]  src_stage;
    logic [NUM_SRC-1:0]        src_badva, src_tlbref;
    logic [NUM_STAGE*32-1:0]   stage_pc, stage_vaddr;
    logic [NUM_STAGE-1:0]      stage_bd, stage_kill;
    logic eret, status_exl, status_erl, status_bev, cause_iv;
    logic [31:0] epc_in, errorepc_in;
    logic [NUM_STAGE-1:0] flush;
    logic [31:0] exc_pc;
    logic use_exc_pc, hold;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] expCount = '0;

    exc_arbiter_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) cop ();

    exc_arbiter dut (
        .clk(clk), .rst(rst),
        .src_req(src_req), .src_code(src_code), .src_stage(src_stage),
        .src_badva(src_badva), .src_tlbref(src_tlbref),
        .stage_pc(stage_pc), .stage_bd(stage_bd), .stage_vaddr(stage_vaddr), .stage_kill(stage_kill),
        .eret(eret), .status_exl(status_exl), .status_erl(status_erl),
        .status_bev(status_bev), .cause_iv(cause_iv),
        .epc_in(epc_in), .errorepc_in(errorepc_in),
        .flush(flush), .exc_pc(exc_pc), .use_exc_pc(use_exc_pc), .hold(hold),
        .cop(cop)
    );

    always #5 clk = ~clk;

    task automatic clearAll;
        src_req = '0; src_code = '0; src_stage = '0; src_badva = '0; src_tlbref = '0;
        stage_pc = '0; stage_vaddr = '0; stage_bd = '0; stage_kill = '0;
        eret = 0; status_exl = 0; status_erl = 0; status_bev = 0; cause_iv = 0;
        epc_in = '0; errorepc_in = '0; cop.exc_ready = 0;
    endtask

    task automatic setSrc(input int idx, input int stg, input int code, input bit bva, input bit tlb);
        src_req[idx] = 1'b1;
        src_stage[idx*STG_W +: STG_W] = STG_W'(stg);
        src_code[idx*CODE_W +: CODE_W] = CODE_W'(code);
        src_badva[idx] = bva;
        src_tlbref[idx] = tlb;
    endtask

    task automatic setStage(input int k, input logic [31:0] pc, input logic [31:0] va, input bit bd);
        stage_pc[k*32 +: 32] = pc;
        stage_vaddr[k*32 +: 32] = va;
        stage_bd[k] = bd;
    endtask

    task automatic accept;
        @(negedge clk);
        src_req = '0; eret = 0; cop.exc_ready = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++; if (cop.exc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cop.exc_valid); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", hold); end
        checks++; if (cop.exc_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0", cop.exc_count); end
        checks++; if ({cop.exc_code, cop.exc_epc, cop.exc_badva, cop.exc_bd, cop.exc_wr_badva} !== '0) begin errors++; $display("FAIL reset_record: code %h epc %h badva %h bd %b wr %b want all 0", cop.exc_code, cop.exc_epc, cop.exc_badva, cop.exc_bd, cop.exc_wr_badva); end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_bd_hold;
        @(negedge clk); clearAll;
        setStage(1, 32'h204, 32'hDEAD_0001, 1); setStage(2, 32'h100, 32'h0, 0);
        setSrc(5, 1, 5'h04, 1, 0);
        #1;
        checks++; if (flush !== 3'b011) begin errors++; $display("FAIL bd_flush: got %b want 011", flush); end
        @(posedge clk); #1; expCount++;
        checks++; if (cop.exc_valid !== 1'b1 || hold !== 1'b1) begin errors++; $display("FAIL bd_valid: valid %b hold %b want 1 1", cop.exc_valid, hold); end
        checks++; if (cop.exc_epc !== 32'h100 || cop.exc_bd !== 1'b1) begin errors++; $display("FAIL bd_epc: epc %h bd %b want 00000100 1", cop.exc_epc, cop.exc_bd); end
        checks++; if (cop.exc_code !== 5'h04 || cop.exc_badva !== 32'hDEAD_0001 || cop.exc_wr_badva !== 1'b1) begin errors++; $display("FAIL bd_record: code %h badva %h wr %b want 04 dead0001 1", cop.exc_code, cop.exc_badva, cop.exc_wr_badva); end
        checks++; if (cop.exc_count !== expCount) begin errors++; $display("FAIL bd_count: got %0d want %0d", cop.exc_count, expCount); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); src_req = '0; setSrc(0, 2, 5'h1F, 0, 0); #1;
            checks++; if (flush !== 3'b000 || use_exc_pc !== 1'b0) begin errors++; $display("FAIL hold_ignore%0d: flush %b use %b want 000 0", c, flush, use_exc_pc); end
            @(posedge clk); #1;
            checks++; if (cop.exc_valid !== 1'b1 || cop.exc_code !== 5'h04 || cop.exc_epc !== 32'h100) begin errors++; $display("FAIL hold_stable%0d: valid %b code %h epc %h want 1 04 00000100", c, cop.exc_valid, cop.exc_code, cop.exc_epc); end
        end
        accept;
        checks++; if (cop.exc_valid !== 1'b0 || hold !== 1'b0) begin errors++; $display("FAIL hold_release: valid %b hold %b want 0 0", cop.exc_valid, hold); end
        checks++; if (cop.exc_count !== 16'd1) begin errors++; $display("FAIL hold_count: got %0d want 1", cop.exc_count); end
    endtask

    task automatic test_priority;
        @(negedge clk); clearAll;
        setStage(0, 32'h1000, 32'h0, 0); setStage(1, 32'h2000, 32'h1234_5678, 0); setStage(2, 32'h3000, 32'h0, 0);
        setSrc(3, 1, 5'h0A, 1, 0); setSrc(7, 2, 5'h0C, 0, 0);
        #1;
        checks++; if (flush !== 3'b011) begin errors++; $display("FAIL prio_flush: got %b want 011", flush); end
        checks++; if (exc_pc !== 32'h8000_0180 || use_exc_pc !== 1'b1) begin errors++; $display("FAIL prio_pc: pc %h use %b want 80000180 1", exc_pc, use_exc_pc); end
        checks++; if (cop.exc_valid !== 1'b0) begin errors++; $display("FAIL prio_early: valid %b want 0", cop.exc_valid); end
        @(posedge clk); #1; expCount++;
        checks++; if (cop.exc_valid !== 1'b1 || cop.exc_code !== 5'h0A) begin errors++; $display("FAIL prio_record: valid %b code %h want 1 0a", cop.exc_valid, cop.exc_code); end
        checks++; if (cop.exc_epc !== 32'h2000 || cop.exc_bd !== 1'b0 || cop.exc_badva !== 32'h1234_5678 || cop.exc_wr_badva !== 1'b1) begin errors++; $display("FAIL prio_epc: epc %h bd %b badva %h wr %b want 00002000 0 12345678 1", cop.exc_epc, cop.exc_bd, cop.exc_badva, cop.exc_wr_badva); end
        accept;
        checks++; if (cop.exc_valid !== 1'b0 || cop.exc_count !== expCount) begin errors++; $display("FAIL prio_accept: valid %b count %0d want 0 %0d", cop.exc_valid, cop.exc_count, expCount); end
    endtask

    task automatic test_vectors;
        @(negedge clk); clearAll;
        setSrc(2, 0, 5'h02, 0, 1); #1;
        checks++; if (exc_pc !== 32'h8000_0000) begin errors++; $display("FAIL vec_tlb: got %h want 80000000", exc_pc); end
        status_exl = 1; #1;
        checks++; if (exc_pc !== 32'h8000_0180) begin errors++; $display("FAIL vec_tlb_exl: got %h want 80000180", exc_pc); end
        status_bev = 1; #1;
        checks++; if (exc_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL vec_bev_exl: got %h want bfc00380", exc_pc); end
        status_exl = 0; #1;
        checks++; if (exc_pc !== 32'hBFC0_0200) begin errors++; $display("FAIL vec_bev_tlb: got %h want bfc00200", exc_pc); end
        src_req = '0; status_bev = 0;
        @(posedge clk); #1;
        checks++; if (cop.exc_valid !== 1'b0) begin errors++; $display("FAIL vec_nocapture: valid %b want 0", cop.exc_valid); end
    endtask

    task automatic test_interrupt;
        @(negedge clk); clearAll;
        setSrc(16, 0, 5'h00, 0, 0); cause_iv = 1; #1;
        checks++; if (exc_pc !== 32'h8000_0200 || flush !== 3'b001) begin errors++; $display("FAIL int_iv: pc %h flush %b want 80000200 001", exc_pc, flush); end
        cause_iv = 0; #1;
        checks++; if (exc_pc !== 32'h8000_0180) begin errors++; $display("FAIL int_noiv: got %h want 80000180", exc_pc); end
        status_exl = 1; #1;
        checks++; if (flush !== 3'b000 || use_exc_pc !== 1'b0) begin errors++; $display("FAIL int_masked: flush %b use %b want 000 0", flush, use_exc_pc); end
        @(posedge clk); #1;
        checks++; if (cop.exc_valid !== 1'b0 || cop.exc_count !== expCount) begin errors++; $display("FAIL int_nohold: valid %b count %0d want 0 %0d", cop.exc_valid, cop.exc_count, expCount); end
    endtask

    task automatic test_kill;
        @(negedge clk); clearAll;
        stage_kill = 3'b010; setSrc(4, 1, 5'h05, 0, 0); setSrc(9, 0, 5'h07, 0, 0); #1;
        checks++; if (flush !== 3'b001) begin errors++; $display("FAIL kill_flush: got %b want 001", flush); end
        @(posedge clk); #1; expCount++;
        checks++; if (cop.exc_code !== 5'h07) begin errors++; $display("FAIL kill_code: got %h want 07", cop.exc_code); end
        accept;
    endtask

    task automatic test_oldest_bd;
        @(negedge clk); clearAll;
        setStage(2, 32'h400, 32'h0, 1); setSrc(1, 2, 5'h0D, 0, 0); #1;
        checks++; if (flush !== 3'b111) begin errors++; $display("FAIL old_flush: got %b want 111", flush); end
        @(posedge clk); #1; expCount++;
        checks++; if (cop.exc_epc !== 32'h3FC || cop.exc_bd !== 1'b1 || cop.exc_wr_badva !== 1'b0) begin errors++; $display("FAIL old_epc: epc %h bd %b wr %b want 000003fc 1 0", cop.exc_epc, cop.exc_bd, cop.exc_wr_badva); end
        accept;
    endtask

    task automatic test_eret;
        @(negedge clk); clearAll;
        eret = 1; status_erl = 1; errorepc_in = 32'hBFC0_0000; epc_in = 32'h8000_1234; #1;
        checks++; if (flush !== 3'b111 || exc_pc !== 32'hBFC0_0000 || use_exc_pc !== 1'b1) begin errors++; $display("FAIL eret_erl: flush %b pc %h use %b want 111 bfc00000 1", flush, exc_pc, use_exc_pc); end
        status_erl = 0; #1;
        checks++; if (exc_pc !== 32'h8000_1234) begin errors++; $display("FAIL eret_epc: got %h want 80001234", exc_pc); end
        @(posedge clk); #1;
        checks++; if (cop.exc_valid !== 1'b0 || hold !== 1'b0 || cop.exc_count !== expCount) begin errors++; $display("FAIL eret_nohold: valid %b hold %b count %0d want 0 0 %0d", cop.exc_valid, hold, cop.exc_count, expCount); end
        @(negedge clk);
        setSrc(6, 0, 5'h03, 0, 0); #1;
        checks++; if (flush !== 3'b001 || exc_pc !== 32'h8000_0180) begin errors++; $display("FAIL eret_vs_exc: flush %b pc %h want 001 80000180", flush, exc_pc); end
        @(posedge clk); #1; expCount++;
        checks++; if (cop.exc_valid !== 1'b1 || cop.exc_code !== 5'h03) begin errors++; $display("FAIL eret_exc_rec: valid %b code %h want 1 03", cop.exc_valid, cop.exc_code); end
        accept;
    endtask

    task automatic test_reset_mid_hold;
        @(negedge clk); clearAll;
        setStage(1, 32'h500, 32'hCAFE_0000, 0); setSrc(8, 1, 5'h11, 1, 0);
        @(posedge clk); #1; expCount++;
        checks++; if (cop.exc_valid !== 1'b1 || cop.exc_count !== expCount) begin errors++; $display("FAIL rh_pre: valid %b count %0d want 1 %0d", cop.exc_valid, cop.exc_count, expCount); end
        @(negedge clk); src_req = '0; rst = 0;
        @(posedge clk); #1; expCount = '0;
        checks++; if (cop.exc_valid !== 1'b0 || hold !== 1'b0) begin errors++; $display("FAIL rh_state: valid %b hold %b want 0 0", cop.exc_valid, hold); end
        checks++; if ({cop.exc_code, cop.exc_epc, cop.exc_badva, cop.exc_bd, cop.exc_wr_badva} !== '0 || cop.exc_count !== 16'h0) begin errors++; $display("FAIL rh_record: code %h epc %h badva %h bd %b wr %b count %0d want all 0", cop.exc_code, cop.exc_epc, cop.exc_badva, cop.exc_bd, cop.exc_wr_badva, cop.exc_count); end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        checks++; if (cop.exc_valid !== 1'b0) begin errors++; $display("FAIL rh_after: valid %b want 0", cop.exc_valid); end
    endtask

    initial begin
        clearAll;
        rst = 0;
        @(posedge clk);
        test_reset;
        test_bd_hold;
        test_priority;
        test_vectors;
        test_interrupt;
        test_kill;
        test_oldest_bd;
        test_eret;
        test_reset_mid_hold;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exc_arbiter.md
Name: exc_arbiter

Overview:
- Parametrised exception arbiter for the CPU pipeline.
- Collects NUM_SRC exception requests, each tagged with a pipeline stage and an exception code.
- Each cycle it selects the highest-priority live request, flushes the affected stages and computes the vector PC.
- The captured record (code, EPC, BD, BadVAddr) is handed to coprocessor 0 over a valid/ready handshake. The pipeline is held until COP0 accepts.

Parameters:
- NUM_SRC, 17: number of exception sources. Index 0 has the highest priority.
- NUM_STAGE, 3: number of pipeline stages that can raise exceptions. Stage 0 is the youngest (IF).
- STG_W, 2: width of each source's stage tag. Must satisfy 2^STG_W >= NUM_STAGE.
- CODE_W, 5: width of the exception code.
- INT_SRC, 16: index of the interrupt source. This source is maskable.
- CNT_W, 16: width of the saturating accepted-exception counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- src_req  in  NUM_SRC  exception request per source.
- src_code  in  NUM_SRC*CODE_W  code per source. Source i occupies bits [i*CODE_W +: CODE_W].
- src_stage  in  NUM_SRC*STG_W  stage tag per source.
- src_badva  in  NUM_SRC  source i updates BadVAddr when taken.
- src_tlbref  in  NUM_SRC  source i uses the TLB-refill vector when taken.
- stage_pc  in  NUM_STAGE*32  PC of each stage.
- stage_bd  in  NUM_STAGE  branch-delay flag of each stage.
- stage_vaddr  in  NUM_STAGE*32  faulting virtual address of each stage.
- stage_kill  in  NUM_STAGE  stage already being flushed; its requests are suppressed.
- eret  in  1  eret in the oldest stage.
- status_exl, status_erl, status_bev, cause_iv  in  1 each  COP0 state.
- epc_in, errorepc_in  in  32 each  COP0 return addresses.
- flush  out  NUM_STAGE  flush per stage.
- exc_pc  out  32  redirect target.
- use_exc_pc  out  1  redirect strobe.
- hold  out  1  pipeline stall while a record is pending.
- exc_valid  out  1  record valid.
- exc_ready  in  1  COP0 accepts the record.
- exc_code  out  CODE_W  captured exception code.
- exc_epc  out  32  captured EPC.
- exc_bd  out  1  captured branch-delay flag.
- exc_badva  out  32  captured BadVAddr.
- exc_wr_badva  out  1  write BadVAddr.
- exc_count  out  CNT_W  accepted-exception count.

Behaviour:
- Live request:
  - live[i] = src_req[i] & ~stage_kill[src_stage[i]].
  - The interrupt source is additionally gated by ~status_exl & ~status_erl & ~hold.
  - All requests are ignored while hold=1.
- Selection: the lowest-index live request wins (sel). Any live request means taken=1.
- Flush: flush[k] = 1 when taken and src_stage[sel] >= k, or when eret is live (eret flushes all stages). Combinational, same cycle as the request.
- If taken and eret occur in the same cycle, the exception wins and eret is ignored.
- Vector offset (before applying BEV):
  - 0x000 if src_tlbref[sel] & ~status_exl.
  - 0x200 if sel==INT_SRC & cause_iv.
  - 0x180 otherwise.
- Vector base: 0xBFC00200 when status_bev=1, else 0x80000000.
- exc_pc:
  - For eret: errorepc_in if status_erl, else epc_in.
  - Otherwise: vector base + offset.
- use_exc_pc = taken | live eret.
- FSM IDLE:
  - On taken, register the record and go to HOLD next cycle.
  - Record: code = src_code[sel].
  - EPC = PC of stage src_stage[sel]. If that stage's bd=1, EPC = PC of stage src_stage[sel]+1 (the branch) and exc_bd=1. At the oldest stage the branch PC is the stage PC − 4.
  - exc_badva = stage_vaddr[src_stage[sel]]; exc_wr_badva = src_badva[sel].
  - exc_count increments, saturating at all-ones.
  - eret does not enter HOLD and does not count.
- FSM HOLD:
  - exc_valid=1 and hold=1.
  - Record outputs are stable until the cycle in which exc_valid & exc_ready.
  - In that cycle: return to IDLE; exc_valid=0 and hold=0 from the next cycle.
  - If exc_ready is already high on the first HOLD cycle, HOLD lasts exactly 1 cycle.
- Latency: request to exc_valid is 1 cycle.
- Reset (rst==0 at a clock edge, including mid-HOLD):
  - State goes to IDLE.
  - exc_valid, hold, exc_wr_badva, exc_bd = 0.
  - exc_code, exc_epc, exc_badva, exc_count = 0.
  - The pending record is discarded.

Test Plan:
- Two sources at stages 1 and 2 (indices 3 and 7) fire together -> index 3 wins; flush=3'b011; exc_code=src_code[3]; exc_valid high 1 cycle later.
- TLB-refill source with status_bev=0, exl=0 -> exc_pc=0x80000000. Same with exl=1 -> 0x80000180. bev=1, exl=0 -> 0xBFC00200.
- Interrupt with cause_iv=1 -> exc_pc=0x80000200. Interrupt with status_exl=1 -> ignored: no flush, exc_valid stays 0.
- Stage-1 exception with stage_bd[1]=1, stage_pc[2]=0x100 -> exc_epc=0x100, exc_bd=1.
- HOLD held 3 cycles with exc_ready=0; a new request in that window -> ignored, record stable. exc_ready=1 -> exc_valid drops next cycle; exc_count = 1.
- rst=0 mid-HOLD -> all outputs 0 next cycle. eret with status_erl=1 -> exc_pc=errorepc_in, flush all ones, no HOLD.
